// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver with a FWFT receive FIFO and RTS flow control.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RTS_THRESH = 3
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rxd,
  output logic             rts,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] c_THRESH = (AW+1)'(RTS_THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic             r_sync1, r_sync2;
  state_t           r_state;
  logic [DIV_W-1:0] r_tick_cnt;
  logic [3:0]       r_smp;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err, r_overrun, r_parity_err, r_rts;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;

  logic             w_tick, w_mid, w_end;
  logic             w_push_req, w_ferr, w_perr;
  logic [AW:0]      w_count, w_count_nxt;
  logic             w_full, w_pop, w_wr;

  assign w_tick = rx_en && (r_state != S_IDLE) && (r_tick_cnt == '0);
  assign w_mid  = w_tick && (r_smp == 4'd7);
  assign w_end  = w_tick && (r_smp == 4'd15);

  assign w_push_req = (r_state == S_STOP) && w_mid && r_sync2;
  assign w_ferr     = (r_state == S_STOP) && w_mid && !r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  assign w_perr = (r_state == S_STOP) && w_mid && (^{r_shift, r_par_bit});
`else
  assign w_perr = 1'b0;
`endif

  assign rx_valid    = (r_wr_ptr != r_rd_ptr);
  assign rx_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_count == c_DEPTH);
  assign w_pop       = rx_valid && rx_ready;
  // A push into a full FIFO is legal when the head is leaving in the same cycle.
  assign w_wr        = w_push_req && (!w_full || w_pop);
  assign w_count_nxt = w_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};

  assign rts        = r_rts;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign parity_err = r_parity_err;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_tick_cnt <= '0;
      r_smp      <= '0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      if (!rx_en || r_state == S_IDLE || r_tick_cnt == '0) begin
        r_tick_cnt <= baud_div;
      end else begin
        r_tick_cnt <= r_tick_cnt - 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_smp <= '0;
      end else if (w_tick) begin
        r_smp <= r_smp + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= w_push_req && w_full && !w_pop;
      if (!rx_en) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (!r_sync2) r_state <= S_START;
          S_START: begin
            if (w_mid && r_sync2) begin
              r_state <= S_IDLE;
            end else if (w_end) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end
          end
          S_DATA: begin
            if (w_mid) r_shift <= {r_sync2, r_shift[7:1]};
            if (w_end) begin
              if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (w_mid) r_par_bit <= r_sync2;
            if (w_end) r_state <= S_STOP;
          end
`endif
          // Leave STOP at mid-bit so the next start edge is never missed.
          S_STOP: if (w_mid) r_state <= r_sync2 ? S_IDLE : S_WAIT_HIGH;
          S_WAIT_HIGH: if (r_sync2) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rts    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rts <= rx_en && (w_count_nxt < c_THRESH);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo at 64 CLK per bit.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;
  localparam int BIT = 64;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        rx_en = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        rxd = 1'b1;
  logic        rx_ready = 1'b1;
  logic        rts, rx_valid, frame_err, overrun, parity_err;
  logic [7:0]  rx_data;

  uart_rx_fifo #(.DIV_W(16), .FIFO_DEPTH(4), .RTS_THRESH(3)) dut (
    .CLK(CLK), .RESETn(RESETn), .rx_en(rx_en), .baud_div(baud_div), .rxd(rxd),
    .rts(rts), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;
  int cyc = 0, edge_cyc = 0, last_pop_cyc = 0;
  int n_pop = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic [7:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESETn) begin
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (parity_err) n_perr++;
      if (rx_valid && rx_ready) begin
        n_pop++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    rxd = 1'b0;
    edge_cyc = cyc;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    step(BIT);
`endif
    rxd = stop;
    step(BIT);
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    step(3);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rts", {31'd0, rts}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    RESETn = 1'b1;
    step(4);
    check("rts_disabled", {31'd0, rts}, 32'd0);
    rx_en = 1'b1;
    step(3);
    check("rts_enabled", {31'd0, rts}, 32'd1);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    step(BIT);
    check("basic_pops", n_pop, 1);
    check("basic_latency_window", {31'd0, ((last_pop_cyc - edge_cyc) inside {[605:620]})}, 32'd1);
    check("basic_valid_dropped", {31'd0, rx_valid}, 32'd0);
    check("basic_no_frame_err", n_ferr, 0);

    rxd = 1'b0;
    step(12);
    rxd = 1'b1;
    step(BIT * 12);
    check("glitch_no_push", n_pop, 1);
    check("glitch_no_frame_err", n_ferr, 0);

    send_frame(8'h3C, 1'b0, ^8'h3C);
    rxd = 1'b0;
    step(2 * BIT);
    rxd = 1'b1;
    step(2 * BIT);
    check("ferr_count", n_ferr, 1);
    check("ferr_no_push", n_pop, 1);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    step(BIT);
    check("after_ferr_pops", n_pop, 2);

    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'h02, 1'b1, ^8'h02);
    check("rts_occ2", {31'd0, rts}, 32'd1);
    send_frame(8'h03, 1'b1, ^8'h03);
    check("rts_occ3", {31'd0, rts}, 32'd0);
    check("fwft_head", {24'd0, rx_data}, 32'h01);
    send_frame(8'h04, 1'b1, ^8'h04);
    check("no_overrun_yet", n_ovr, 0);
    send_frame(8'h05, 1'b1, ^8'h05);
    step(BIT);
    check("overrun_count", n_ovr, 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(2);
    check("rts_after_pop1", {31'd0, rts}, 32'd0);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(2);
    check("rts_after_pop2", {31'd0, rts}, 32'd1);
    rx_ready = 1'b1;
    step(2);
    rx_ready = 1'b0;
    step(2);
    check("drained_valid", {31'd0, rx_valid}, 32'd0);
    check("drained_pops", n_pop, 6);

    send_frame(8'h5A, 1'b1, ^8'h5A);
    step(BIT);
    check("held_valid", {31'd0, rx_valid}, 32'd1);
    check("held_data", {24'd0, rx_data}, 32'h5A);
    d = 8'h7E;
    rxd = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      step(BIT);
    end
    rxd = d[4];
    step(BIT / 2);
    RESETn = 1'b0;
    #1;
    check("midreset_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rts", {31'd0, rts}, 32'd0);
    step(2);
    RESETn = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    step(2 * BIT);
    check("postreset_rts", {31'd0, rts}, 32'd1);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    step(BIT);
    check("postreset_pops", n_pop, 7);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    step(BIT);
    check("parity_bad_flagged", n_perr, 1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    step(BIT);
    check("parity_good_clean", n_perr, 1);
    check("parity_pops", n_pop, 9);
`else
    check("parity_err_never", n_perr, 0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
